// File: rtl/sweep_learn_ctrl.sv
// Frequency-response learning sweep sequencer: steps the DDS controller through
// NUM_STEPS codes, measures ADC peak-to-peak per step and writes it to the response RAM.
module sweep_learn_ctrl #(
  parameter int SETTLE_CYC = 50000,
  parameter int MEAS_CYC   = 500000,
  parameter int NUM_STEPS  = 97,
  parameter int DW         = 10,
  parameter int AW         = 7
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 adc_valid,
  input  logic signed [DW-1:0] adc_data,
  output logic                 learn_en,
  output logic                 next_freq,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW:0]          wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int PULSE_CYC = 4;
  localparam int MAX_A     = (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
  localparam int MAX_CNT   = (MAX_A > PULSE_CYC) ? MAX_A : PULSE_CYC;
  localparam int CW        = $clog2(MAX_CNT);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] MEAS_LAST   = CW'(MEAS_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
  localparam logic [AW-1:0] STEP_LAST   = AW'(NUM_STEPS - 1);

  // Extremes are seeded opposite so the first valid sample wins both compares.
  localparam logic signed [DW-1:0] MAX_SEED = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MIN_SEED = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEAS,
    WRITE,
    STEP,
    FINISH
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         step_idx;
  logic signed [DW-1:0]  max_r, min_r;
  logic                  seen_r;

  logic signed [DW-1:0]  max_nxt, min_nxt;
  logic                  seen_nxt;
  logic [DW:0]           p2p;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    max_nxt  = max_r;
    min_nxt  = min_r;
    seen_nxt = seen_r;
    if (adc_valid) begin
      if (adc_data > max_r) max_nxt = adc_data;
      if (adc_data < min_r) min_nxt = adc_data;
      seen_nxt = 1'b1;
    end
    // One extra bit keeps full-scale swings (max - min up to 2^DW - 1) from wrapping.
    p2p = {max_nxt[DW-1], max_nxt} - {min_nxt[DW-1], min_nxt};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      step_idx  <= '0;
      max_r     <= '0;
      min_r     <= '0;
      seen_r    <= 1'b0;
      learn_en  <= 1'b0;
      next_freq <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      cnt       <= '0;
      step_idx  <= '0;
      learn_en  <= 1'b0;
      next_freq <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= SETTLE;
            cnt      <= '0;
            step_idx <= '0;
            learn_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state  <= MEAS;
            cnt    <= '0;
            max_r  <= MAX_SEED;
            min_r  <= MIN_SEED;
            seen_r <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MEAS: begin
          max_r  <= max_nxt;
          min_r  <= min_nxt;
          seen_r <= seen_nxt;
          if (cnt == MEAS_LAST) begin
            // Result includes the sample arriving on the final window cycle.
            state   <= WRITE;
            cnt     <= '0;
            wr_en   <= 1'b1;
            wr_addr <= step_idx;
            wr_data <= seen_nxt ? p2p : '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          cnt <= '0;
          if (step_idx == STEP_LAST) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state     <= STEP;
            next_freq <= 1'b1;
          end
        end
        STEP: begin
          if (cnt == PULSE_LAST) begin
            state     <= SETTLE;
            cnt       <= '0;
            next_freq <= 1'b0;
            step_idx  <= step_idx + AW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FINISH: begin
          state    <= IDLE;
          done     <= 1'b0;
          learn_en <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          learn_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
